serial_adder16: RTL and testbench



---
 rtl/arith_pkg.sv | 20 ++
 rtl/full_adder.sv | 20 ++
 rtl/serial_adder16.sv | 127 ++++++++++++
 tb/tb_serial_adder16.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: sequencer state encoding, default operand width
// and the bit-counter width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_e;

    localparam int ADD_WIDTH_DEF = 16;

    // Counter must reach WIDTH-1; never narrower than one bit.
    function automatic int add_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int ADD_CNT_W_DEF = add_cnt_w(ADD_WIDTH_DEF);

endpackage

// File: rtl/full_adder.sv
// Gate-level one-bit full adder cell; structural twin of the full subtractor cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output wire  s,
    output wire  cout
);

    wire ab_x;
    wire ab_a;
    wire c_a;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (s, ab_x, cin);
    and g_a0 (ab_a, a, b);
    and g_a1 (c_a, ab_x, cin);
    or  g_o0 (cout, ab_a, c_a);

endmodule

// File: rtl/serial_adder16.sv
// Bit-serial two's-complement adder, one bit per clock through a single full_adder.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder16
    import arith_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = add_cnt_w(WIDTH);

    add_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             fa_s;
    logic             fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    full_adder u_fa (
        .a    (shift_a_q[0]),
        .b    (shift_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        res_d     = res_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    shift_a_d = a;
                    shift_b_d = b;
                    carry_d   = cin;
                    cnt_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
                shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
                res_d     = {fa_s, res_q[WIDTH-1:1]};
                carry_d   = fa_cout;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB
                    ovf_d   = carry_q ^ fa_cout;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            res_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            res_q     <= res_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder16.sv
// Directed scoreboard bench for serial_adder16 (optional ovf checked when
// SERIAL_ADDER_OVF_EN is defined).
module tb_serial_adder16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   done_seen = 0;
    int   pushed   = 0;

    serial_adder16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t       e;
        logic [W:0] full;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return e;
    endfunction

    // Scoreboard consumer: each done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sum", 64'(sum), 64'(e.sum));
                chk("cout", 64'(cout), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit push);
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        if (push) begin
            sb.push_back(model(x, y, c));
            pushed++;
        end
        step(1);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cin   = 1'($urandom_range(1));
    endtask

    task automatic wait_done_high(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            step(1);
            k++;
        end
        if (done !== 1'b1) chk({tag, "_timeout"}, 64'(done), 64'd1);
    endtask

    initial begin
        int busy_cnt;
        int done_early;
        int d0;
        int sum_moved;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         rc;

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;
        step(2);

        // Basic add with latency and busy-length check
        do_start(16'h1234, 16'h1111, 1'b0, 1'b1);
        busy_cnt   = 0;
        done_early = 0;
        for (int i = 0; i < W; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done !== 1'b0) done_early++;
            if (i < W - 1) step(1);
        end
        chk("busy_cycles", 64'(busy_cnt), 64'(W));
        chk("done_early", 64'(done_early), 64'd0);
        step(1);
        chk("done_latency", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd0);
        chk("sum_basic_at_done", 64'(sum), 64'h2345);
        step(1);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("sum_hold_idle", 64'(sum), 64'h2345);
        step(2);

        // Reset in the middle of RUN
        d0 = done_seen;
        do_start(16'h1234, 16'h1111, 1'b0, 1'b0);
        step(4);
        chk("midrun_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_sum", 64'(sum), 64'd0);
        chk("midrun_rst_cout", 64'(cout), 64'd0);
        chk("midrun_rst_done", 64'(done), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(25);
        chk("midrun_no_done", 64'(done_seen), 64'(d0));
        chk("midrun_idle_busy", 64'(busy), 64'd0);

        // Wrap / carry
        do_start(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        wait_done_high("wrap");
        step(2);

        // Signed overflow through carry-in
        do_start(16'h7FFF, 16'h0000, 1'b1, 1'b1);
        wait_done_high("ovf");
        step(2);

        // Start while busy is ignored
        d0 = done_seen;
        do_start(16'h00FF, 16'h0101, 1'b0, 1'b1);
        step(2);
        a = 16'h0F0F;
        b = 16'h0F0F;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(30);
        chk("busy_start_one_done", 64'(done_seen - d0), 64'd1);
        chk("busy_start_sum", 64'(sum), 64'h0200);

        // Back-to-back: new start held in the DONE cycle
        do_start(16'h0005, 16'h0006, 1'b0, 1'b1);
        wait_done_high("b2b_first");
        d0 = done_seen;
        do_start(16'h0001, 16'h0002, 1'b0, 1'b1);
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_done_low", 64'(done), 64'd0);
        sum_moved = 0;
        for (int i = 0; i < W - 1; i++) begin
            if (sum !== 16'h000B) sum_moved++;
            step(1);
        end
        chk("b2b_sum_held", 64'(sum_moved), 64'd0);
        wait_done_high("b2b_second");
        chk("b2b_sum", 64'(sum), 64'h0003);
        step(2);
        chk("b2b_two_dones", 64'(done_seen - d0), 64'd2);

        // A few random operands
        for (int i = 0; i < 4; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom_range(1));
            do_start(rx, ry, rc, 1'b1);
            wait_done_high("rand");
            step(1);
        end

        step(3);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("done_total", 64'(done_seen), 64'(pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
